// File: rtl/four_bit_rcs.sv
// four_bit_rcs: 4-bit ripple-carry adder/subtractor with registered outputs.
// Sub=0 computes A+B. Sub=1 computes A-B: B is inverted and Sub is fed in as
// the carry-in. The core is a four-stage ripple of full-adder cells.
// Optional macro FOUR_BIT_RCS_OVERFLOW_EN adds the registered signed-overflow
// output V (c3 ^ c4).
module four_bit_rcs (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Sub,
    output logic [3:0] S,
`ifdef FOUR_BIT_RCS_OVERFLOW_EN
    output logic       V,
`endif
    output logic       Cout
);

    // B after the conditional inversion; this is the B input of each cell
    logic [3:0] b_eff;
    // Ripple carry chain: carry[0] is the injected carry-in, carry[4] is the carry-out
    logic [4:0] carry;
    // Combinational sum bits from the cells
    logic [3:0] sum;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_binv
            assign b_eff[gi] = B[gi] ^ Sub;
        end
    endgenerate

    // Ripple the carry through four full-adder cells, least significant bit first
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = Sub;
        for (int i = 0; i < 4; i++) begin
            sum[i]     = A[i] ^ b_eff[i] ^ carry[i];
            carry[i+1] = (A[i] & b_eff[i]) | (carry[i] & (A[i] ^ b_eff[i]));
        end
    end

    // Capture the result and carry-out each edge; asynchronous clear to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S    <= 4'b0000;
            Cout <= 1'b0;
        end else begin
            S    <= sum;
            Cout <= carry[4];
        end
    end

`ifdef FOUR_BIT_RCS_OVERFLOW_EN
    // Signed overflow: the carry into the sign bit differs from the carry out of it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            V <= 1'b0;
        end else begin
            V <= carry[3] ^ carry[4];
        end
    end
`endif

endmodule

// File: tb/tb_four_bit_rcs.sv
// Scoreboard testbench for four_bit_rcs: stimulus pushes expected results from
// an arithmetic reference model, a monitor pops and compares one edge later.
module tb_four_bit_rcs;

    logic       clk;
    logic       rst_n;
    logic [3:0] A;
    logic [3:0] B;
    logic       Sub;
    logic [3:0] S;
    logic       Cout;
`ifdef FOUR_BIT_RCS_OVERFLOW_EN
    logic       V;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         a;
        int         b;
        int         sub;
        logic [3:0] s;
        logic       c;
        logic       v;
    } exp_t;

    exp_t exp_q[$];

    four_bit_rcs dut (
        .clk  (clk),
        .rst_n(rst_n),
        .A    (A),
        .B    (B),
        .Sub  (Sub),
        .S    (S),
`ifdef FOUR_BIT_RCS_OVERFLOW_EN
        .V    (V),
`endif
        .Cout (Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on unsigned and signed views
    function automatic exp_t model(input int a, input int b, input int sub);
        exp_t e;
        int total, sa, sb, r;
        total = (sub != 0) ? (a + 16 - b) : (a + b);
        sa    = (a >= 8) ? a - 16 : a;
        sb    = (b >= 8) ? b - 16 : b;
        r     = (sub != 0) ? (sa - sb) : (sa + sb);
        e.a   = a;
        e.b   = b;
        e.sub = sub;
        e.s   = 4'(total % 16);
        e.c   = (total >= 16);
        e.v   = (r > 7) || (r < -8);
        return e;
    endfunction

    task automatic apply(input int a, input int b, input int sub);
        @(negedge clk);
        A   = 4'(a);
        B   = 4'(b);
        Sub = (sub != 0);
        exp_q.push_back(model(a, b, sub));
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results still pending, required 0", exp_q.size());
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (S !== 4'b0000 || Cout !== 1'b0) begin
            errors++;
            $display("FAIL %s: S=%b Cout=%b, required S=0000 Cout=0", name, S, Cout);
        end
`ifdef FOUR_BIT_RCS_OVERFLOW_EN
        checks++;
        if (V !== 1'b0) begin
            errors++;
            $display("FAIL %s_v: V=%b, required 0", name, V);
        end
`endif
    endtask

    // Monitor: every edge out of reset presents one result for the oldest stimulus
    always @(posedge clk) begin
        #1;
        if (rst_n && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (S !== e.s || Cout !== e.c) begin
                errors++;
                $display("FAIL result A=%0d B=%0d Sub=%0d: S=%b Cout=%b, required S=%b Cout=%b",
                         e.a, e.b, e.sub, S, Cout, e.s, e.c);
            end else begin
                $display("txn A=%0d B=%0d Sub=%0d -> S=%b Cout=%b", e.a, e.b, e.sub, S, Cout);
            end
`ifdef FOUR_BIT_RCS_OVERFLOW_EN
            checks++;
            if (V !== e.v) begin
                errors++;
                $display("FAIL overflow A=%0d B=%0d Sub=%0d: V=%b, required %b",
                         e.a, e.b, e.sub, V, e.v);
            end
`endif
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int dir_a[9]   = '{6, 15, 5, 9, 1, 15, 8, 0, 7};
        int dir_b[9]   = '{5, 15, 3, 4, 2, 1, 1, 0, 7};
        int dir_sub[9] = '{0, 0, 1, 1, 1, 1, 1, 1, 1};

        rst_n = 1'b0;
        A     = 4'd0;
        B     = 4'd0;
        Sub   = 1'b0;
        #3;
        check_zero("power_on_reset");
        @(posedge clk);
        #1;
        check_zero("reset_held");
        @(negedge clk);
        rst_n = 1'b1;

        // First result after release
        apply(5, 3, 0);
        drain();

        // Directed vectors back to back: one new input set per cycle
        for (int i = 0; i < 9; i++) apply(dir_a[i], dir_b[i], dir_sub[i]);
        apply(15, 15, 0);
        drain();

        // Asynchronous reset mid-cycle with nonzero outputs (15+15 registered)
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        @(posedge clk);
        #1;
        check_zero("reset_hold_edge");
        @(negedge clk);
        rst_n = 1'b1;
        apply(5, 3, 0);
        drain();

        // Exhaustive sweep, inputs changing every cycle
        for (int sub = 0; sub < 2; sub++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    apply(a, b, sub);
        drain();

        // Random traffic
        for (int i = 0; i < 200; i++)
            apply(int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(1)));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/four_bit_rcs.md
Name: four_bit_rcs

Overview:
- 4-bit ripple-carry adder/subtractor with registered outputs. It is a single arithmetic datapath leaf used by the project ALU.
- Sub=0 computes A+B. Sub=1 computes A-B by two's complement: B is inverted through XOR gates and Sub is injected as the carry-in.
- Structure is a chain of four 1-bit full adders. The result and carry-out are captured in output registers on the rising clock edge.

Parameters:
- None. Width is fixed at 4 bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- A  input  4  operand A (unsigned or two's-complement)
- B  input  4  operand B (unsigned or two's-complement)
- Sub  input  1  operation select: 0 = add, 1 = subtract
- S  output  4  registered sum/difference, modulo 16
- Cout  output  1  registered carry-out of bit 3

Behaviour:
- Reset: when rst_n=0, S=4'b0000 and Cout=0 immediately (asynchronous), held while rst_n is low. After release, the first update occurs on the next rising clk edge.
- Combinational core:
  - Bb[i] = B[i] XOR Sub; c0 = Sub.
  - Full adder i: s[i] = A[i]^Bb[i]^c[i]; c[i+1] = A[i]&Bb[i] | c[i]&(A[i]^Bb[i]).
  - Must be a true 4-stage ripple of full-adder cells, not a behavioural "+".
- Arithmetic result: {c4, s} = A + (B ^ {4{Sub}}) + Sub, exact and modulo 16.
- Registering: on every rising clk edge with rst_n=1, S <= s[3:0] and Cout <= c4.
  - Latency is 1 cycle from inputs to outputs. There is no enable and no handshake; inputs are sampled every cycle.
- Carry semantics:
  - Add: Cout=1 means unsigned overflow (A+B > 15).
  - Subtract: Cout=1 means no borrow (A >= B unsigned); Cout=0 means borrow (A < B).
- Signed interpretation: S is the two's-complement result wrapped to 4 bits, e.g. -8-1 yields 0111. No saturation.
- Boundary cases:
  - A=B with Sub=1 gives S=0000, Cout=1.
  - A=0, B=0, Sub=1 gives S=0000, Cout=1.
  - 15+15 gives S=1110, Cout=1.
- Changing Sub mid-stream takes effect on the next captured edge. There is no internal state beyond the output registers.
- Reset asserted mid-operation discards the pending result; outputs go to 0 at once.

Optional Feature:
- Macro: FOUR_BIT_RCS_OVERFLOW_EN.
- Defined:
  - Adds output port V (1 bit), the registered signed overflow flag: V <= c3 XOR c4.
  - Reset value of V is 0. V has the same 1-cycle latency as S.
- Undefined:
  - Port V and its register do not exist.
  - All other behaviour is identical.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle with nonzero outputs -> S=0000, Cout=0 immediately (V=0 if enabled). Release rst_n, apply A=0101, B=0011, Sub=0 -> one edge later S=1000, Cout=0 (V=1).
- Unsigned add: A=0110, B=0101, Sub=0 -> S=1011, Cout=0 (V=1). A=1111, B=1111, Sub=0 -> S=1110, Cout=1 (V=0).
- Unsigned subtract: A=0101, B=0011, Sub=1 -> S=0010, Cout=1. A=1001, B=0100, Sub=1 -> S=0101, Cout=1 (V=1).
- Negative results: A=0001, B=0010, Sub=1 -> S=1111, Cout=0 (V=0). A=1111, B=0001, Sub=1 -> S=1110, Cout=1 (V=0).
- Signed wrap: A=1000, B=0001, Sub=1 -> S=0111, Cout=1 (V=1).
- Latency/pipelining: change inputs every cycle through the vectors above -> each result appears exactly one rising edge after its inputs.
- Exhaustive: all 512 combinations of A, B and Sub checked against the reference model {Cout,S} = A + (B^{4{Sub}}) + Sub.
